// File: rtl/mac_sched_pkg.sv
// Shared definitions for the MAC pass scheduler: controller states,
// slot geometry and the slot-walking helper used by the result drain.
package mac_sched_pkg;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    localparam int SLOT_NUM   = 4;
    localparam int SLOT_IDX_W = 2;

    // Returned by next_set_slot when no further slot qualifies
    localparam logic [2:0] NO_SLOT = 3'd4;

    // Lowest slot index at or above fromSlot whose mask bit is set, else NO_SLOT.
    // fromSlot is one bit wider than a slot index so "one past the last slot" is expressible.
    function automatic logic [2:0] next_set_slot(input logic [SLOT_NUM-1:0] mask,
                                                 input logic [2:0]          fromSlot);
        logic [2:0] found;
        found = NO_SLOT;
        for (int i = SLOT_NUM - 1; i >= 0; i--) begin
            if (mask[i] && (3'(i) >= fromSlot)) begin
                found = 3'(i);
            end
        end
        return found;
    endfunction

endpackage

// File: rtl/mac_pass_sched.sv
// Pass scheduler for a single MAC_UNIT datapath. Accepts compressed
// (activation, weight, slot) triples, issues one MAC per triple choosing
// restart versus accumulate per slot, then snapshots the four partial-sum
// slots at end of pass and streams them out on a valid/ready result port.
module mac_pass_sched
    import mac_sched_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int SKIP_EMPTY     = 0,
    parameter int PASS_CNT_WIDTH = 16
) (
    input  logic                        Clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_WIDTH-1:0]       in_act,
    input  logic [DATA_WIDTH-1:0]       in_weight,
    input  logic [1:0]                  in_idx,
    input  logic                        in_last,
    output logic [DATA_WIDTH-1:0]       mac_act,
    output logic [DATA_WIDTH-1:0]       mac_weight,
    output logic [1:0]                  mac_select,
    output logic                        mac_block_control,
    input  logic [4*DATA_WIDTH-1:0]     mac_out_0,
    input  logic [4*DATA_WIDTH-1:0]     mac_out_1,
    input  logic [4*DATA_WIDTH-1:0]     mac_out_2,
    input  logic [4*DATA_WIDTH-1:0]     mac_out_3,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [4*DATA_WIDTH-1:0]     res_data,
    output logic [1:0]                  res_idx,
    output logic                        res_last,
    output logic [PASS_CNT_WIDTH-1:0]   pass_cnt
);

    localparam int ACC_W = 4 * DATA_WIDTH;

    state_t                       r_state;
    logic [SLOT_NUM-1:0]          r_initFlag;
    logic [SLOT_NUM-1:0]          r_mask;
    logic [SLOT_IDX_W-1:0]        r_ptr;
    logic [ACC_W-1:0]             r_buf [SLOT_NUM];
    logic                         r_inReady;
    logic                         r_resValid;
    logic [ACC_W-1:0]             r_resData;
    logic [SLOT_IDX_W-1:0]        r_resIdx;
    logic                         r_resLast;
    logic [PASS_CNT_WIDTH-1:0]    r_passCnt;
    logic [SLOT_IDX_W-1:0]        r_macSelPrev;

    logic                         w_inFire;
    logic                         w_resFire;
    logic [ACC_W-1:0]             w_macOut [SLOT_NUM];
    logic [ACC_W-1:0]             w_capVal [SLOT_NUM];
    logic [SLOT_NUM-1:0]          w_capMask;
    logic [SLOT_NUM-1:0]          w_drainMask;
    logic [2:0]                   w_capFirst;
    logic                         w_capLast;
    logic [2:0]                   w_nextPtr;
    logic                         w_nextLast;
    logic [DATA_WIDTH-1:0]        w_macAct;
    logic [DATA_WIDTH-1:0]        w_macWeight;
    logic [SLOT_IDX_W-1:0]        w_macSelect;
    logic                         w_macBlockControl;

    assign w_inFire  = in_valid & r_inReady & (r_state == ACCUM);
    assign w_resFire = r_resValid & res_ready;

    assign w_macOut[0] = mac_out_0;
    assign w_macOut[1] = mac_out_1;
    assign w_macOut[2] = mac_out_2;
    assign w_macOut[3] = mac_out_3;

    // With skipping disabled every slot is emitted, so the walk mask is all ones
    assign w_capMask   = (SKIP_EMPTY != 0) ? r_initFlag : {SLOT_NUM{1'b1}};
    assign w_drainMask = (SKIP_EMPTY != 0) ? r_mask     : {SLOT_NUM{1'b1}};

    assign w_capFirst = next_set_slot(w_capMask, 3'd0);
    assign w_capLast  = (next_set_slot(w_capMask, w_capFirst + 3'd1) == NO_SLOT);
    assign w_nextPtr  = next_set_slot(w_drainMask, {1'b0, r_ptr} + 3'd1);
    assign w_nextLast = (next_set_slot(w_drainMask, w_nextPtr + 3'd1) == NO_SLOT);

    // Snapshot value per slot: slots untouched this pass hold stale sums, so report zero
    always_comb begin
        for (int n = 0; n < SLOT_NUM; n++) begin
            w_capVal[n] = r_initFlag[n] ? w_macOut[n] : '0;
        end
    end

    // MAC operand steering: issue on handshake, expose/clear in CAPTURE, otherwise hold slots
    always_comb begin
        w_macAct          = '0;
        w_macWeight       = '0;
        w_macSelect       = r_macSelPrev;
        w_macBlockControl = 1'b1;
        case (r_state)
            ACCUM: begin
                if (w_inFire) begin
                    w_macAct          = in_act;
                    w_macWeight       = in_weight;
                    w_macSelect       = in_idx;
                    w_macBlockControl = r_initFlag[in_idx];
                end
            end
            CAPTURE: begin
                w_macSelect       = '0;
                w_macBlockControl = 1'b0;
            end
            default: begin
            end
        endcase
    end

    // Remember the last select so idle cycles keep pointing at the same slot
    always_ff @(posedge Clk) begin
        if (!rst) begin
            r_macSelPrev <= '0;
        end else begin
            r_macSelPrev <= w_macSelect;
        end
    end

    // Latch the slot snapshot while the MAC exposes its outputs in CAPTURE
    always_ff @(posedge Clk) begin
        if (!rst) begin
            for (int n = 0; n < SLOT_NUM; n++) begin
                r_buf[n] <= '0;
            end
        end else if (r_state == CAPTURE) begin
            for (int n = 0; n < SLOT_NUM; n++) begin
                r_buf[n] <= w_capVal[n];
            end
        end
    end

    // Pass controller: accumulate triples, capture slots, drain results, count passes
    always_ff @(posedge Clk) begin
        if (!rst) begin
            r_state    <= ACCUM;
            r_initFlag <= '0;
            r_mask     <= '0;
            r_ptr      <= '0;
            r_inReady  <= 1'b0;
            r_resValid <= 1'b0;
            r_resData  <= '0;
            r_resIdx   <= '0;
            r_resLast  <= 1'b0;
            r_passCnt  <= '0;
        end else begin
            case (r_state)
                ACCUM: begin
                    r_inReady <= 1'b1;
                    if (w_inFire) begin
                        r_initFlag[in_idx] <= 1'b1;
                        if (in_last) begin
                            r_state   <= CAPTURE;
                            r_inReady <= 1'b0;
                        end
                    end
                end
                CAPTURE: begin
                    r_initFlag <= '0;
                    r_mask     <= r_initFlag;
                    r_ptr      <= w_capFirst[SLOT_IDX_W-1:0];
                    r_resValid <= 1'b1;
                    r_resData  <= w_capVal[w_capFirst[SLOT_IDX_W-1:0]];
                    r_resIdx   <= w_capFirst[SLOT_IDX_W-1:0];
                    r_resLast  <= w_capLast;
                    r_state    <= DRAIN;
                end
                DRAIN: begin
                    if (w_resFire) begin
                        if (r_resLast) begin
                            r_resValid <= 1'b0;
                            r_resLast  <= 1'b0;
                            r_passCnt  <= r_passCnt + 1'b1;
                            r_inReady  <= 1'b1;
                            r_state    <= ACCUM;
                        end else begin
                            r_ptr     <= w_nextPtr[SLOT_IDX_W-1:0];
                            r_resData <= r_buf[w_nextPtr[SLOT_IDX_W-1:0]];
                            r_resIdx  <= w_nextPtr[SLOT_IDX_W-1:0];
                            r_resLast <= w_nextLast;
                        end
                    end
                end
                default: begin
                    r_state   <= ACCUM;
                    r_inReady <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready          = r_inReady;
    assign mac_act           = w_macAct;
    assign mac_weight        = w_macWeight;
    assign mac_select        = w_macSelect;
    assign mac_block_control = w_macBlockControl;
    assign res_valid         = r_resValid;
    assign res_data          = r_resData;
    assign res_idx           = r_resIdx;
    assign res_last          = r_resLast;
    assign pass_cnt          = r_passCnt;

endmodule

// File: tb/tb_mac_pass_sched.sv
// Bench for mac_pass_sched: two instances (SKIP_EMPTY=0 and =1) share the
// triple stream, each driving its own behavioural MAC slot model. Expected
// results come from per-pass slot sums kept by the stimulus side.
module tb_mac_pass_sched;

    typedef struct {
        logic [1:0]  idx;
        logic [31:0] data;
        logic        last;
    } res_t;

    logic                  Clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  in_valid = 1'b0;
    logic [7:0]            in_act = '0;
    logic [7:0]            in_weight = '0;
    logic [1:0]            in_idx = '0;
    logic                  in_last = 1'b0;

    logic [1:0]            inReady;
    logic [1:0][7:0]       macAct;
    logic [1:0][7:0]       macWt;
    logic [1:0][1:0]       macSel;
    logic [1:0]            macBc;
    logic [1:0][3:0][31:0] macOut;
    logic [1:0][3:0][31:0] slot;
    logic [1:0]            resValid;
    logic [1:0]            resReady = '0;
    logic [1:0][31:0]      resData;
    logic [1:0][1:0]       resIdx;
    logic [1:0]            resLast;
    logic [1:0][15:0]      passCnt;

    res_t        expQ [2][$];
    res_t        logQ [2][$];
    int          expPass [2];
    int unsigned mSum [4];
    bit          mHit [4];
    bit          holdReady = 1'b0;
    int          numChecks = 0;
    int          numPassed = 0;

    always #5 Clk = ~Clk;

    mac_pass_sched #(.DATA_WIDTH(8), .SKIP_EMPTY(0), .PASS_CNT_WIDTH(16)) u0 (
        .Clk(Clk), .rst(rst),
        .in_valid(in_valid), .in_ready(inReady[0]), .in_act(in_act), .in_weight(in_weight),
        .in_idx(in_idx), .in_last(in_last),
        .mac_act(macAct[0]), .mac_weight(macWt[0]), .mac_select(macSel[0]),
        .mac_block_control(macBc[0]),
        .mac_out_0(macOut[0][0]), .mac_out_1(macOut[0][1]),
        .mac_out_2(macOut[0][2]), .mac_out_3(macOut[0][3]),
        .res_valid(resValid[0]), .res_ready(resReady[0]), .res_data(resData[0]),
        .res_idx(resIdx[0]), .res_last(resLast[0]), .pass_cnt(passCnt[0])
    );

    mac_pass_sched #(.DATA_WIDTH(8), .SKIP_EMPTY(1), .PASS_CNT_WIDTH(16)) u1 (
        .Clk(Clk), .rst(rst),
        .in_valid(in_valid), .in_ready(inReady[1]), .in_act(in_act), .in_weight(in_weight),
        .in_idx(in_idx), .in_last(in_last),
        .mac_act(macAct[1]), .mac_weight(macWt[1]), .mac_select(macSel[1]),
        .mac_block_control(macBc[1]),
        .mac_out_0(macOut[1][0]), .mac_out_1(macOut[1][1]),
        .mac_out_2(macOut[1][2]), .mac_out_3(macOut[1][3]),
        .res_valid(resValid[1]), .res_ready(resReady[1]), .res_data(resData[1]),
        .res_idx(resIdx[1]), .res_last(resLast[1]), .pass_cnt(passCnt[1])
    );

    // MAC datapath model: write act*weight (+ old slot when accumulating) every edge
    always @(posedge Clk) begin
        for (int k = 0; k < 2; k++) begin
            slot[k][macSel[k]] <= 32'(macAct[k]) * 32'(macWt[k]) +
                                  (macBc[k] ? slot[k][macSel[k]] : 32'd0);
        end
    end

    // Slot outputs are only meaningful while Block_control is low; otherwise drive junk
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 4; n++) begin
                macOut[k][n] = macBc[k] ? 32'hDEAD_BEEF : slot[k][n];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        numChecks++;
        if (actual === expected) begin
            numPassed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Compare one instance's result port and pass counter against the expected queue
    task automatic compareRes(input int k);
        res_t e;
        res_t seen;
        if (!rst) return;
        checkOutput($sformatf("passCnt%0d", k), 64'(passCnt[k]), 64'(expPass[k]));
        if (expQ[k].size() == 0) begin
            checkOutput($sformatf("validIdle%0d", k), 64'(resValid[k]), 64'd0);
        end else if (resValid[k]) begin
            e = expQ[k][0];
            checkOutput($sformatf("resData%0d", k), 64'(resData[k]), 64'(e.data));
            checkOutput($sformatf("resIdx%0d", k), 64'(resIdx[k]), 64'(e.idx));
            checkOutput($sformatf("resLast%0d", k), 64'(resLast[k]), 64'(e.last));
            if (resReady[k]) begin
                e = expQ[k].pop_front();
                seen.idx  = resIdx[k];
                seen.data = resData[k];
                seen.last = resLast[k];
                logQ[k].push_back(seen);
                if (e.last) expPass[k] = (expPass[k] + 1) % 65536;
            end
        end
    endtask

    always @(negedge Clk) begin
        compareRes(0);
        compareRes(1);
    end

    task automatic stepCycle();
        @(posedge Clk);
        #1;
        if (holdReady) begin
            resReady = '0;
        end else begin
            resReady[0] = ($urandom_range(0, 3) != 0);
            resReady[1] = ($urandom_range(0, 3) != 0);
        end
    endtask

    // Send one triple once both instances are ready, and fold it into the pass model
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] w,
                                 input logic [1:0] i, input logic l);
        int   waitCnt;
        int   lastHit;
        res_t e;
        waitCnt  = 0;
        in_valid = 1'b0;
        while (inReady != 2'b11 && waitCnt < 300) begin
            stepCycle();
            waitCnt++;
        end
        if (inReady != 2'b11) begin
            checkOutput("inReadyTimeout", 64'(inReady), 64'd3);
            return;
        end
        in_valid  = 1'b1;
        in_act    = a;
        in_weight = w;
        in_idx    = i;
        in_last   = l;
        stepCycle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        mSum[i] = mSum[i] + 32'(a) * 32'(w);
        mHit[i] = 1'b1;
        if (l) begin
            lastHit = 0;
            for (int n = 0; n < 4; n++) begin
                e.idx  = 2'(n);
                e.data = mHit[n] ? mSum[n] : 32'd0;
                e.last = (n == 3);
                expQ[0].push_back(e);
                if (mHit[n]) lastHit = n;
            end
            for (int n = 0; n < 4; n++) begin
                if (mHit[n]) begin
                    e.idx  = 2'(n);
                    e.data = mSum[n];
                    e.last = (n == lastHit);
                    expQ[1].push_back(e);
                end
            end
            for (int n = 0; n < 4; n++) begin
                mSum[n] = 0;
                mHit[n] = 1'b0;
            end
        end
    endtask

    task automatic waitDrain();
        int waitCnt;
        waitCnt = 0;
        while ((expQ[0].size() != 0 || expQ[1].size() != 0 || resValid != 2'b00) && waitCnt < 400) begin
            stepCycle();
            waitCnt++;
        end
        if (expQ[0].size() != 0 || expQ[1].size() != 0 || resValid != 2'b00) begin
            checkOutput("drainTimeout", 64'd1, 64'd0);
        end
    endtask

    task automatic checkLog(input int k, input int pos, input logic [1:0] idx,
                            input logic [31:0] data, input logic last);
        if (logQ[k].size() <= pos) begin
            checkOutput($sformatf("logSize%0d", k), 64'(logQ[k].size()), 64'(pos + 1));
        end else begin
            checkOutput($sformatf("logIdx%0d_%0d", k, pos), 64'(logQ[k][pos].idx), 64'(idx));
            checkOutput($sformatf("logData%0d_%0d", k, pos), 64'(logQ[k][pos].data), 64'(data));
            checkOutput($sformatf("logLast%0d_%0d", k, pos), 64'(logQ[k][pos].last), 64'(last));
        end
    endtask

    task automatic clearLogs();
        logQ[0].delete();
        logQ[1].delete();
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] heldData;
        logic [1:0]  heldIdx;
        int          waitCnt;
        int          len;

        expPass[0] = 0;
        expPass[1] = 0;
        for (int n = 0; n < 4; n++) begin
            mSum[n] = 0;
            mHit[n] = 1'b0;
        end

        // Reset and reset values
        rst = 1'b0;
        repeat (3) stepCycle();
        rst = 1'b1;
        stepCycle();
        for (int k = 0; k < 2; k++) begin
            checkOutput("rstInReady", 64'(inReady[k]), 64'd1);
            checkOutput("rstResValid", 64'(resValid[k]), 64'd0);
            checkOutput("rstResData", 64'(resData[k]), 64'd0);
            checkOutput("rstResIdx", 64'(resIdx[k]), 64'd0);
            checkOutput("rstResLast", 64'(resLast[k]), 64'd0);
            checkOutput("rstPassCnt", 64'(passCnt[k]), 64'd0);
        end

        // Basic pass: slot0 = 3*4 + 2*5 = 22, slot2 = 7
        clearLogs();
        applyStimulus(8'd3, 8'd4, 2'd0, 1'b0);
        applyStimulus(8'd2, 8'd5, 2'd0, 1'b0);
        applyStimulus(8'd7, 8'd1, 2'd2, 1'b1);
        waitDrain();
        checkLog(0, 0, 2'd0, 32'd22, 1'b0);
        checkLog(0, 1, 2'd1, 32'd0, 1'b0);
        checkLog(0, 2, 2'd2, 32'd7, 1'b0);
        checkLog(0, 3, 2'd3, 32'd0, 1'b1);
        checkOutput("skipLogSize", 64'(logQ[1].size()), 64'd2);
        checkLog(1, 0, 2'd0, 32'd22, 1'b0);
        checkLog(1, 1, 2'd2, 32'd7, 1'b1);
        checkOutput("passCntA0", 64'(passCnt[0]), 64'd1);
        checkOutput("passCntA1", 64'(passCnt[1]), 64'd1);

        // Second pass restarts slot0 from zero
        clearLogs();
        applyStimulus(8'd1, 8'd1, 2'd0, 1'b1);
        waitDrain();
        checkLog(0, 0, 2'd0, 32'd1, 1'b0);
        checkLog(1, 0, 2'd0, 32'd1, 1'b1);
        checkOutput("passCntB0", 64'(passCnt[0]), 64'd2);

        // Backpressure: outputs stable, in_ready low, stray in_valid ignored
        applyStimulus(8'd5, 8'd6, 2'd1, 1'b1);
        waitCnt = 0;
        while (!(resValid[0] && resValid[1]) && waitCnt < 20) begin
            stepCycle();
            waitCnt++;
        end
        holdReady = 1'b1;
        resReady  = '0;
        heldData  = resData[0];
        heldIdx   = resIdx[0];
        checkOutput("holdStartValid", 64'(resValid[0]), 64'd1);
        for (int c = 0; c < 5; c++) begin
            in_valid  = 1'b1;
            in_act    = 8'($urandom_range(0, 255));
            in_weight = 8'($urandom_range(0, 255));
            in_idx    = 2'($urandom_range(0, 3));
            stepCycle();
            checkOutput("holdInReady", 64'(inReady), 64'd0);
            checkOutput("holdData", 64'(resData[0]), 64'(heldData));
            checkOutput("holdIdx", 64'(resIdx[0]), 64'(heldIdx));
        end
        in_valid  = 1'b0;
        holdReady = 1'b0;
        waitDrain();

        // Gapped stream on slot3: 255*255 + 1*2 = 65027
        clearLogs();
        applyStimulus(8'd255, 8'd255, 2'd3, 1'b0);
        repeat (3) stepCycle();
        applyStimulus(8'd1, 8'd2, 2'd3, 1'b1);
        waitDrain();
        checkLog(0, 3, 2'd3, 32'd65027, 1'b1);
        checkLog(1, 0, 2'd3, 32'd65027, 1'b1);

        // Reset while the unskipped instance is presenting slot 1
        applyStimulus(8'd3, 8'd3, 2'd0, 1'b0);
        applyStimulus(8'd4, 8'd4, 2'd1, 1'b0);
        applyStimulus(8'd5, 8'd5, 2'd3, 1'b1);
        waitCnt = 0;
        while (!(resValid[0] && resIdx[0] == 2'd1) && waitCnt < 100) begin
            stepCycle();
            waitCnt++;
        end
        checkOutput("reachPtr1", 64'(resIdx[0]), 64'd1);
        rst = 1'b0;
        expQ[0].delete();
        expQ[1].delete();
        expPass[0] = 0;
        expPass[1] = 0;
        stepCycle();
        rst = 1'b1;
        checkOutput("midRstValid", 64'(resValid), 64'd0);
        checkOutput("midRstPass0", 64'(passCnt[0]), 64'd0);
        checkOutput("midRstPass1", 64'(passCnt[1]), 64'd0);
        clearLogs();
        applyStimulus(8'd2, 8'd3, 2'd1, 1'b1);
        waitDrain();
        checkLog(0, 1, 2'd1, 32'd6, 1'b0);
        checkLog(1, 0, 2'd1, 32'd6, 1'b1);
        checkOutput("postRstPass", 64'(passCnt[0]), 64'd1);

        // Randomized passes with random gaps and random result backpressure
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(1, 6);
            for (int t = 0; t < len; t++) begin
                applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                              2'($urandom_range(0, 3)), (t == len - 1));
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 2)) stepCycle();
                end
            end
        end
        waitDrain();
        checkOutput("finalPass0", 64'(passCnt[0]), 64'd41);
        checkOutput("finalPass1", 64'(passCnt[1]), 64'd41);

        $display("%0d/%0d checks passed", numPassed, numChecks);
        $finish;
    end

endmodule
